// File: rtl/adunare_pipelined_if.sv
// Operand/result handshake bundle for the pipelined chunked adder.
// The producer drives operands and consumes results (master). The adder sits on the slave side.
interface adunare_pipelined_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             c0;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, x, y, c0, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, x, y, c0, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/adunare_pipelined.sv
// WIDTH-bit add/subtract split into CHUNK-bit slices, one pipeline stage per slice.
// The carry between slices is registered, so the critical path is a single CHUNK-bit add.
// Each stage forwards only the operand chunks that are not yet added, plus the sum chunks
// produced so far. The whole pipe advances together and freezes when the result is blocked.
module adunare_pipelined #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic               clk,
   input  logic               rst,
   adunare_pipelined_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;

   logic adv_s;
   logic ovf_r;

   // The pipe moves when the output slot is empty or is being drained this cycle.
   assign adv_s        = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - k * CHUNK;

      logic [REM-1:0]         rem_a_s;
      logic [REM-1:0]         rem_b_s;
      logic                   cin_s;
      logic                   vin_s;
      logic [CHUNK:0]         add_s;
      logic [(k+1)*CHUNK-1:0] sum_s;
      logic [(k+1)*CHUNK-1:0] sum_r;
      logic                   carry_r;
      logic                   valid_r;

      if (k == 0) begin : g_head
         // Subtraction becomes x + ~y + ~c0, so y and c0 are conditioned once, at acceptance.
         assign rem_a_s = bus.x;
         assign rem_b_s = bus.sub ? ~bus.y : bus.y;
         assign cin_s   = bus.sub ? ~bus.c0 : bus.c0;
         assign vin_s   = bus.in_valid;
         assign sum_s   = add_s[CHUNK-1:0];
      end else begin : g_body
         assign rem_a_s = g_stage[k-1].g_fwd.a_r;
         assign rem_b_s = g_stage[k-1].g_fwd.b_r;
         assign cin_s   = g_stage[k-1].carry_r;
         assign vin_s   = g_stage[k-1].valid_r;
         assign sum_s   = {add_s[CHUNK-1:0], g_stage[k-1].sum_r};
      end

      assign add_s = {1'b0, rem_a_s[CHUNK-1:0]}
                   + {1'b0, rem_b_s[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cin_s};

      // Stage valid follows the pipe on every advance; data only loads for real transactions
      // so the visible result stays put across bubbles.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_r <= 1'b0;
            carry_r <= 1'b0;
            sum_r   <= '0;
         end else if (adv_s) begin
            valid_r <= vin_s;
            if (vin_s) begin
               carry_r <= add_s[CHUNK];
               sum_r   <= sum_s;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [REM-CHUNK-1:0] a_r;
         logic [REM-CHUNK-1:0] b_r;

         // Carry the still-unadded upper operand chunks down to the next stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_r <= '0;
               b_r <= '0;
            end else if (adv_s && vin_s) begin
               a_r <= rem_a_s[REM-1:CHUNK];
               b_r <= rem_b_s[REM-1:CHUNK];
            end
         end
      end

      if (k == STAGES - 1) begin : g_tail
         // Signed overflow: carry into the MSB (a^b^sum at the MSB) differs from carry out.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_r <= 1'b0;
            end else if (adv_s && vin_s) begin
               ovf_r <= rem_a_s[CHUNK-1] ^ rem_b_s[CHUNK-1] ^ add_s[CHUNK-1] ^ add_s[CHUNK];
            end
         end
      end
   end

   assign bus.out_valid = g_stage[STAGES-1].valid_r;
   assign bus.s         = g_stage[STAGES-1].sum_r;
   assign bus.cout      = g_stage[STAGES-1].carry_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_adunare_pipelined.sv
// Bench for the pipelined chunked adder. It uses a 16/4 build for the directed cases and a
// 32/8 build for the parametric case plus a random run against an integer reference model.
module tb_adunare_pipelined;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   typedef struct {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t exp_q[$];

   adunare_pipelined_if #(.WIDTH(16)) bus16 ();
   adunare_pipelined_if #(.WIDTH(32)) bus32 ();

   adunare_pipelined #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   adunare_pipelined #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arithmetic reference: exact integer add/subtract, then range tests for carry and overflow.
   function automatic res_t ref_model(input int w, input longint x, input longint y,
                                      input bit c0, input bit sub);
      res_t   r;
      longint m, half, sx, sy, ci, u, sr;
      m    = 64'sd1 <<< w;
      half = m / 64'sd2;
      sx   = (x >= half) ? x - m : x;
      sy   = (y >= half) ? y - m : y;
      ci   = c0 ? 64'sd1 : 64'sd0;
      if (sub) begin
         u      = x - y - ci;
         sr     = sx - sy - ci;
         r.cout = (u >= 64'sd0);
      end else begin
         u      = x + y + ci;
         sr     = sx + sy + ci;
         r.cout = (u >= m);
      end
      r.s   = 32'((u + m) % m);
      r.ovf = (sr >= half) || (sr < -half);
      return r;
   endfunction

   // One transaction on the 16-bit build with out_ready high; checks latency and result.
   task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic c0, input logic sub,
                       input logic [15:0] es, input logic ecout, input logic eovf);
      int lat;
      bus16.in_valid  = 1'b1;
      bus16.x         = x;
      bus16.y         = y;
      bus16.c0        = c0;
      bus16.sub       = sub;
      bus16.out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(bus16.in_ready), 64'd1);
      tick();
      bus16.in_valid = 1'b0;
      bus16.x        = 16'hDEAD;
      bus16.y        = 16'hBEEF;
      bus16.sub      = ~sub;
      lat = 1;
      while (!bus16.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_s"}, 64'(bus16.s), 64'(es));
      check({tag, "_cout"}, 64'(bus16.cout), 64'(ecout));
      check({tag, "_ovf"}, 64'(bus16.ovf), 64'(eovf));
      tick();
      check({tag, "_no_dup"}, 64'(bus16.out_valid), 64'd0);
   endtask

   initial begin
      int          issued;
      int          got;
      int          cyc;
      int          stall_left;
      int          n_stall;
      int          lat;
      bit          seen;
      bit          prev_stall;
      logic [15:0] held16;
      logic [31:0] held32;
      res_t        e;

      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b1;
      bus16.in_valid = 1'b0; bus16.x = 16'h0000; bus16.y = 16'h0000;
      bus16.c0 = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
      bus32.in_valid = 1'b0; bus32.x = 32'h0; bus32.y = 32'h0;
      bus32.c0 = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
      check("rst_s", 64'(bus16.s), 64'd0);
      check("rst_cout", 64'(bus16.cout), 64'd0);
      check("rst_ovf", 64'(bus16.ovf), 64'd0);
      check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
      check("rst_out_valid32", 64'(bus32.out_valid), 64'd0);

      // Directed arithmetic on the 16-bit build
      op16("add_basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      op16("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      op16("sub_neg",    16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16("sub_borrow", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

      // Backpressure: six back-to-back adds, consumer stalls 3 cycles at the first result
      issued = 0; got = 0; cyc = 0; stall_left = 0; n_stall = 0; seen = 1'b0;
      held16 = 16'h0000;
      while (got < 6 && cyc < 60) begin
         bus16.in_valid = (issued < 6);
         bus16.x        = 16'(issued);
         bus16.y        = 16'h1000;
         bus16.c0       = 1'b0;
         bus16.sub      = 1'b0;
         if (bus16.out_valid && !seen) begin
            seen       = 1'b1;
            stall_left = 3;
            held16     = bus16.s;
         end
         bus16.out_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            check("bp_in_ready_stall", 64'(bus16.in_ready), 64'd0);
            check("bp_s_held", 64'(bus16.s), 64'(held16));
            check("bp_valid_held", 64'(bus16.out_valid), 64'd1);
            stall_left--;
            n_stall++;
         end else begin
            check("bp_in_ready", 64'(bus16.in_ready), 64'd1);
         end
         if (bus16.in_valid && bus16.in_ready) issued++;
         if (bus16.out_valid && bus16.out_ready) begin
            check("bp_result", 64'(bus16.s), 64'(16'(16'h1000 + got)));
            got++;
         end
         tick();
         cyc++;
      end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      check("bp_count", 64'(got), 64'd6);
      check("bp_stall_cycles", 64'(n_stall), 64'd3);
      check("bp_held_first", 64'(held16), 64'h1000);
      tick();
      check("bp_drained", 64'(bus16.out_valid), 64'd0);

      // Reset mid-flight: three accepted ops plus a fourth presented alongside rst
      for (int i = 0; i < 3; i++) begin
         bus16.in_valid = 1'b1;
         bus16.x        = 16'(16'h0100 * (i + 1));
         bus16.y        = 16'h0011;
         #1;
         check("mid_accept", 64'(bus16.in_ready), 64'd1);
         tick();
      end
      bus16.x = 16'h0777;
      rst     = 1'b1;
      tick();
      rst            = 1'b0;
      bus16.in_valid = 1'b0;
      check("mid_rst_out_valid", 64'(bus16.out_valid), 64'd0);
      check("mid_rst_s", 64'(bus16.s), 64'd0);
      for (int i = 0; i < 8; i++) begin
         check("mid_no_ghost", 64'(bus16.out_valid), 64'd0);
         tick();
      end
      op16("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

      // Parametric 32/8 build: signed overflow on add, latency four
      bus32.in_valid  = 1'b1;
      bus32.x         = 32'h7FFFFFFF;
      bus32.y         = 32'h00000001;
      bus32.c0        = 1'b0;
      bus32.sub       = 1'b0;
      bus32.out_ready = 1'b1;
      #1;
      tick();
      bus32.in_valid = 1'b0;
      lat = 1;
      while (!bus32.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("w32_latency", 64'(lat), 64'd4);
      check("w32_s", 64'(bus32.s), 64'h80000000);
      check("w32_ovf", 64'(bus32.ovf), 64'd1);
      check("w32_cout", 64'(bus32.cout), 64'd0);
      tick();

      // Random run on the 32/8 build with random valid and out_ready
      issued = 0; got = 0; cyc = 0; prev_stall = 1'b0; held32 = 32'h0;
      while ((issued < 1000 || got < issued) && cyc < 20000) begin
         if (prev_stall) begin
            check("rnd_hold_valid", 64'(bus32.out_valid), 64'd1);
            check("rnd_hold_s", 64'(bus32.s), 64'(held32));
         end
         bus32.in_valid  = (issued < 1000) && ($urandom_range(3) != 0);
         bus32.x         = $urandom();
         bus32.y         = $urandom();
         bus32.c0        = 1'($urandom_range(1));
         bus32.sub       = 1'($urandom_range(1));
         bus32.out_ready = ($urandom_range(9) < 7);
         #1;
         check("rnd_in_ready", 64'(bus32.in_ready),
               64'(!bus32.out_valid || bus32.out_ready));
         if (bus32.in_valid && bus32.in_ready) begin
            exp_q.push_back(ref_model(32, longint'(bus32.x), longint'(bus32.y),
                                      bus32.c0, bus32.sub));
            issued++;
         end
         if (bus32.out_valid && bus32.out_ready) begin
            check("rnd_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rnd_s", 64'(bus32.s), 64'(e.s));
               check("rnd_cout", 64'(bus32.cout), 64'(e.cout));
               check("rnd_ovf", 64'(bus32.ovf), 64'(e.ovf));
               got++;
            end
         end
         prev_stall = bus32.out_valid && !bus32.out_ready;
         held32     = bus32.s;
         tick();
         cyc++;
      end
      check("rnd_issued", 64'(issued), 64'd1000);
      check("rnd_got", 64'(got), 64'd1000);
      check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
